secure_regfile: RTL and testbench

//  Parametrised successor of the core integer register file: XLEN x NREGS array, two write ports
//  (ALU writeback, memory writeback), three registered read ports (rs1, rs2, store data).

---
 rtl/secure_regfile.sv | 154 +++++++++++++++
 tb/tb_secure_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/secure_regfile.sv
// Integer register file (2 write, 3 registered read ports) with a key-gated protected register window.
// Latency: reads return 1 cycle after the address is presented; writes commit on the same rising edge.
// Backpressure: none, every port accepts every cycle; blocked protected accesses are dropped and flagged.
// Optional feature: define RF_BYPASS_EN to forward same-cycle permitted writes to the read ports.
module secure_regfile #(
  parameter int          XLEN           = 32,
  parameter int          NREGS          = 32,
  parameter int          PROT_REGS      = 4,
  parameter logic [15:0] KEY_VALUE      = 16'h0032,
  parameter int          UNLOCK_CYCLES  = 16,
  parameter int          LOCKOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wen_alu,
  input  logic [$clog2(NREGS)-1:0] waddr_alu,
  input  logic [XLEN-1:0]          wdata_alu,
  input  logic                     wen_mem,
  input  logic [$clog2(NREGS)-1:0] waddr_mem,
  input  logic [XLEN-1:0]          wdata_mem,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  input  logic [$clog2(NREGS)-1:0] raddr3,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  output logic [XLEN-1:0]          rdata3,
  input  logic                     unlock_req,
  input  logic [15:0]              unlock_key,
  input  logic                     lock_req,
  output logic                     unlocked,
  output logic                     lockout,
  output logic                     prot_viol
);

  localparam int AW   = $clog2(NREGS);
  localparam int MAXC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] CNT_UNL = CW'(UNLOCK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LO  = CW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_LOCKOUT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic            win_open;
  logic            alu_ok;
  logic            mem_ok;
  logic            viol_now;

  // Top PROT_REGS addresses form the protected window; an empty window never matches.
  function automatic logic is_prot(input logic [AW-1:0] a);
    return (PROT_REGS > 0) && (int'(a) >= (NREGS - PROT_REGS));
  endfunction

  // Read value for one port: x0 and blocked window reads are zero; optional same-cycle forwarding.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = regs[a];
`ifdef RF_BYPASS_EN
    if (mem_ok && (waddr_mem == a)) v = wdata_mem;
    if (alu_ok && (waddr_alu == a)) v = wdata_alu;
`endif
    if ((a == '0) || (is_prot(a) && !win_open)) v = '0;
    return v;
  endfunction

  // Permission is taken from the state held at the start of the cycle, never the next state.
  assign win_open = (state == S_UNLOCKED);

  // Qualify each write port; ALU wins a same-address collision so the memory write is dropped.
  always_comb begin
    alu_ok   = wen_alu && (waddr_alu != '0) && (!is_prot(waddr_alu) || win_open);
    mem_ok   = wen_mem && (waddr_mem != '0) && (!is_prot(waddr_mem) || win_open)
               && !(wen_alu && (waddr_alu == waddr_mem));
    viol_now = !win_open && ((wen_alu && is_prot(waddr_alu)) || (wen_mem && is_prot(waddr_mem))
               || is_prot(raddr1) || is_prot(raddr2) || is_prot(raddr3));
  end

  // Lock state machine: good key opens the window for UNLOCK_CYCLES, bad key blocks requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOCKED;
      cnt      <= '0;
      unlocked <= 1'b0;
      lockout  <= 1'b0;
    end else begin
      case (state)
        S_LOCKED: begin
          if (unlock_req) begin
            if (unlock_key == KEY_VALUE) begin
              state    <= S_UNLOCKED;
              cnt      <= CNT_UNL;
              unlocked <= 1'b1;
            end else begin
              state   <= S_LOCKOUT;
              cnt     <= CNT_LO;
              lockout <= 1'b1;
            end
          end
        end
        S_UNLOCKED: begin
          if (lock_req || (cnt == '0)) begin
            state    <= S_LOCKED;
            cnt      <= '0;
            unlocked <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (cnt == '0) begin
            state   <= S_LOCKED;
            lockout <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= S_LOCKED;
          cnt      <= '0;
          unlocked <= 1'b0;
          lockout  <= 1'b0;
        end
      endcase
    end
  end

  // Register array: x0 is never written since the qualifiers exclude address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (mem_ok) regs[waddr_mem] <= wdata_mem;
      if (alu_ok) regs[waddr_alu] <= wdata_alu;
    end
  end

  // Registered read ports and the one-cycle violation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1    <= '0;
      rdata2    <= '0;
      rdata3    <= '0;
      prot_viol <= 1'b0;
    end else begin
      rdata1    <= read_port(raddr1);
      rdata2    <= read_port(raddr2);
      rdata3    <= read_port(raddr3);
      prot_viol <= viol_now;
    end
  end

endmodule

// File: tb/tb_secure_regfile.sv
// Bench for secure_regfile: directed scenarios plus randomized traffic against a reference model.
// The model tracks the lock window as absolute cycle deadlines and the register file as a plain array.
module tb_secure_regfile;

  localparam int          NREGS = 32;
  localparam int          PROT  = 4;
  localparam int          UCYC  = 16;
  localparam int          LCYC  = 64;
  localparam logic [15:0] KEY   = 16'h0032;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen_alu, wen_mem, unlock_req, lock_req;
  logic [4:0]  waddr_alu, waddr_mem, raddr1, raddr2, raddr3;
  logic [31:0] wdata_alu, wdata_mem;
  logic [15:0] unlock_key;
  logic [31:0] rdata1, rdata2, rdata3;
  logic        unlocked, lockout, prot_viol;

  always #5 clk = ~clk;

  secure_regfile #(
    .XLEN(32), .NREGS(NREGS), .PROT_REGS(PROT), .KEY_VALUE(KEY),
    .UNLOCK_CYCLES(UCYC), .LOCKOUT_CYCLES(LCYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wen_alu(wen_alu), .waddr_alu(waddr_alu), .wdata_alu(wdata_alu),
    .wen_mem(wen_mem), .waddr_mem(waddr_mem), .wdata_mem(wdata_mem),
    .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
    .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
    .unlock_req(unlock_req), .unlock_key(unlock_key), .lock_req(lock_req),
    .unlocked(unlocked), .lockout(lockout), .prot_viol(prot_viol)
  );

  // Reference model state
  logic [31:0] mreg [NREGS];
  int          cyc, unl_end, lo_end;
  logic [31:0] exp_rd1, exp_rd2, exp_rd3;
  logic        exp_viol, exp_unl, exp_lo;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_unl, n_lo;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
  endtask

  function automatic bit prot(input logic [4:0] a);
    return int'(a) >= (NREGS - PROT);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit unl, input bit aok, input bit mok);
    if (a == 5'd0 || (prot(a) && !unl)) return 32'h0;
    if (BYP && aok && waddr_alu == a) return wdata_alu;
    if (BYP && mok && waddr_mem == a) return wdata_mem;
    return mreg[a];
  endfunction

  task automatic idle;
    wen_alu = 0; waddr_alu = 0; wdata_alu = 0;
    wen_mem = 0; waddr_mem = 0; wdata_mem = 0;
    raddr1 = 0; raddr2 = 0; raddr3 = 0;
    unlock_req = 0; unlock_key = 0; lock_req = 0;
  endtask

  // One clock: predict from current inputs and model, advance the model, then wait past the edge.
  task automatic tick;
    int t;
    bit unl, lo, aok, mok, v;
    logic [31:0] e1, e2, e3;
    t   = cyc;
    unl = t < unl_end;
    lo  = t < lo_end;
    aok = wen_alu && waddr_alu != 0 && (unl || !prot(waddr_alu));
    mok = wen_mem && waddr_mem != 0 && (unl || !prot(waddr_mem)) && !(wen_alu && waddr_alu == waddr_mem);
    e1  = model_read(raddr1, unl, aok, mok);
    e2  = model_read(raddr2, unl, aok, mok);
    e3  = model_read(raddr3, unl, aok, mok);
    v   = !unl && ((wen_alu && prot(waddr_alu)) || (wen_mem && prot(waddr_mem)) ||
                   prot(raddr1) || prot(raddr2) || prot(raddr3));
    if (!unl && !lo && unlock_req) begin
      if (unlock_key == KEY) unl_end = t + 1 + UCYC;
      else                   lo_end  = t + 1 + LCYC;
    end else if (unl && lock_req) begin
      unl_end = t + 1;
    end
    if (mok) mreg[waddr_mem] = wdata_mem;
    if (aok) mreg[waddr_alu] = wdata_alu;
    @(posedge clk);
    #1;
    exp_rd1 = e1; exp_rd2 = e2; exp_rd3 = e3; exp_viol = v;
    exp_unl = (t + 1) < unl_end;
    exp_lo  = (t + 1) < lo_end;
    cyc     = t + 1;
    chk_en  = 1'b1;
  endtask

  // Assert reset (async), check cleared outputs, then release between edges.
  task automatic do_reset;
    chk_en = 1'b0;
    idle();
    rst_n = 1'b0;
    #3;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);
    check("rst_rdata3", rdata3, 32'h0);
    check("rst_unlocked", unlocked, 0);
    check("rst_lockout", lockout, 0);
    check("rst_prot_viol", prot_viol, 0);
    for (int i = 0; i < NREGS; i++) mreg[i] = 32'h0;
    cyc = 0; unl_end = 0; lo_end = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 5'($urandom_range(0, 31));
      2:       return 5'($urandom_range(28, 31));
      default: return 5'd9;
    endcase
  endfunction

  // Continuous comparison of every output against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("cmp_rdata1", rdata1, exp_rd1);
      check("cmp_rdata2", rdata2, exp_rd2);
      check("cmp_rdata3", rdata3, exp_rd3);
      check("cmp_prot_viol", prot_viol, exp_viol);
      check("cmp_unlocked", unlocked, exp_unl);
      check("cmp_lockout", lockout, exp_lo);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    do_reset();

    // Basic write/read
    raddr1 = 5; tick(); check("t1_r5_reset", rdata1, 32'h0);
    wen_alu = 1; waddr_alu = 5; wdata_alu = 32'hDEADBEEF; raddr1 = 5; tick();
    idle(); raddr1 = 5; tick(); check("t1_r5_written", rdata1, 32'hDEADBEEF);

    // Port collision and x0
    idle(); wen_alu = 1; waddr_alu = 7; wdata_alu = 32'h1; wen_mem = 1; waddr_mem = 7; wdata_mem = 32'h2; tick();
    idle(); raddr2 = 7; tick(); check("t2_alu_wins", rdata2, 32'h1);
    idle(); wen_alu = 1; waddr_alu = 0; wdata_alu = 32'hFFFF; raddr3 = 0; tick(); check("t2_r0_same_cycle", rdata3, 32'h0);
    idle(); raddr3 = 0; tick(); check("t2_r0", rdata3, 32'h0);

    // Locked window
    idle(); wen_alu = 1; waddr_alu = 31; wdata_alu = 32'hA5A5; tick(); check("t3_viol_write", prot_viol, 1);
    idle(); tick(); check("t3_viol_clear", prot_viol, 0);
    idle(); raddr1 = 31; tick(); check("t3_r31_zero", rdata1, 32'h0); check("t3_viol_read", prot_viol, 1);

    // Good key: window length, same-cycle block, read-back and relock
    idle(); unlock_req = 1; unlock_key = 16'h0032; wen_alu = 1; waddr_alu = 30; wdata_alu = 32'h55; tick();
    check("t4_unlocked", unlocked, 1); check("t4_same_cycle_blocked", prot_viol, 1);
    n_unl = 1;
    idle(); wen_alu = 1; waddr_alu = 30; wdata_alu = 32'h55; tick(); n_unl += int'(unlocked);
    idle(); raddr1 = 30; tick(); n_unl += int'(unlocked); check("t4_r30_open", rdata1, 32'h55);
    for (int i = 0; i < 40 && unlocked; i++) begin tick(); n_unl += int'(unlocked); end
    check("t4_window_len", n_unl, 16);
    check("t4_final_cycle_read", rdata1, 32'h55);
    tick(); check("t4_r30_relocked", rdata1, 32'h0);
    idle(); unlock_req = 1; unlock_key = 16'h0032; tick();
    idle(); tick(); tick(); check("t4_still_open", unlocked, 1);
    lock_req = 1; tick(); check("t4_lock_req", unlocked, 0);

    // Bad key: lockout length, requests ignored
    idle(); unlock_req = 1; unlock_key = 16'h0033; tick(); check("t5_lockout", lockout, 1);
    n_lo = 1;
    unlock_key = 16'h0032; tick(); n_lo += int'(lockout); check("t5_key_ignored", unlocked, 0);
    idle();
    for (int i = 0; i < 100 && lockout; i++) begin tick(); n_lo += int'(lockout); end
    check("t5_lockout_len", n_lo, 64);
    unlock_req = 1; unlock_key = 16'h0032; tick(); check("t5_accept_after", unlocked, 1);
    idle(); lock_req = 1; tick();

    // Same-cycle forwarding
    idle(); wen_alu = 1; waddr_alu = 9; wdata_alu = 32'h77; raddr2 = 9; tick();
    check("t6_bypass", rdata2, BYP ? 32'h77 : 32'h0);
    idle(); raddr2 = 9; tick(); check("t6_r9", rdata2, 32'h77);

    // Reset in the middle of an open window
    idle(); unlock_req = 1; unlock_key = 16'h0032; tick();
    idle(); wen_alu = 1; waddr_alu = 30; wdata_alu = 32'h99; tick(); check("rw_open", unlocked, 1);
    do_reset();
    idle(); raddr1 = 5; raddr2 = 9; tick();
    check("rw_r5_cleared", rdata1, 32'h0); check("rw_r9_cleared", rdata2, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      wen_alu    = 1'($urandom_range(0, 1));
      waddr_alu  = rand_addr();
      wdata_alu  = $urandom;
      wen_mem    = 1'($urandom_range(0, 1));
      waddr_mem  = rand_addr();
      wdata_mem  = $urandom;
      raddr1     = rand_addr();
      raddr2     = rand_addr();
      raddr3     = rand_addr();
      unlock_req = ($urandom_range(0, 19) == 0);
      unlock_key = ($urandom_range(0, 1) == 1) ? KEY : 16'($urandom);
      lock_req   = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
